uart_tx: RTL and testbench
==========================

# uart_tx

Runtime-configurable UART transmitter, the transmit counterpart of the `uart_rx` path in the serial front end. It serializes one 7- or 8-bit word per frame as start bit, data LSB first, optional parity bit, then stop interval. Bit timing derives from the shared oversample tick `s_tick`. Frame format is programmable at run time, so the same bitstream serves every line configuration the receiver supports.

## Interface
- `DBIT`, default 8: width of data storage; the runtime `dbit` value is ≤ DBIT.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `dbit`  in  4  data bits per frame: 7 sends `din[6:0]`; any other value sends 8 bits, `din[7:0]`.
- `pbit`  in  2  parity mode: 0 = none, 1 = even, 2 = odd, 3 = none.
- `sb_tick`  in  8  stop interval length in `s_tick` pulses (e.g. 16, 24 or 32 for 1, 1.5 or 2 stop bits at `os_tick` = 16).
- `os_tick`  in  8  `s_tick` pulses per bit, e.g. 16 or 32.
- `s_tick`  in  1  one-cycle oversample enable from the shared baud generator.
- `tx_start`  in  1  request to send `din`; sampled only when `ready` = 1.
- `din`  in  DBIT  word to transmit.
- `tx`  out  1  serial line, registered; idle level 1.
- `ready`  out  1  1 iff FSM is in `idle`.
- `tx_done_tick`  out  1  one-cycle pulse at end of the stop interval.

## Operation
- **States:** `idle`, `start`, `data`, `parity`, `stop`.
- **Registers:** state, 8-bit tick counter `s`, 3-bit bit counter `n`, DBIT shift register `b`, latched parity bit `p`, `tx_reg`.
- **idle:** `tx_reg` = 1.
  - On `tx_start`, latch `b` ← `din`, clear `s` and `n`, and compute `p` from `din` using the current `dbit`/`pbit`, then go to `start`.
  - `dbit`, `pbit`, `sb_tick` and `os_tick` must be held stable from acceptance until `tx_done_tick`; behaviour if they change mid-frame is undefined.
- **start:** `tx_reg` = 0.
  - On each `s_tick`: if `s` == `os_tick`−1, clear `s` and go to `data`; otherwise increment `s`.
- **data:** `tx_reg` = `b[0]`.
  - On each `s_tick` with `s` == `os_tick`−1: clear `s` and shift `b` right.
  - If `n` == data width−1, clear `n` and go to `parity` if mode is even/odd, else to `stop`. Otherwise increment `n`.
- **parity:** `tx_reg` = `p`.
  - Even parity: `p` = XOR of transmitted data bits.
  - Odd parity: `p` = inverse of that XOR.
  - After `os_tick` ticks, go to `stop`.
- **stop:** `tx_reg` = 1.
  - On the `s_tick` where `s` == `sb_tick`−1: pulse `tx_done_tick` combinationally and go to `idle`.
- **Width rules:** all comparisons are 8-bit modulo, so `os_tick` = 0 or `sb_tick` = 0 yields 256 ticks. For 7-bit frames, `din[DBIT-1:7]` is ignored.
- **Timing source:** no `s_tick` means no progress; the FSM holds state indefinitely.

## Timing
- **Reset:** state = `idle`, `tx` = 1, `ready` = 1, `tx_done_tick` = 0, all counters 0. Reset mid-frame returns `tx` to 1 asynchronously; a partial frame is abandoned and `tx_done_tick` is not asserted.
- **Acceptance latency:** `tx_start` sampled at clock edge k (while `ready`) makes `tx` = 0 and `ready` = 0 from edge k onward.
- **Bit widths:** every bit lasts exactly `os_tick` `s_tick` pulses, and each bit transition occurs on the clock edge that samples the terminal `s_tick`. The stop interval lasts exactly `sb_tick` pulses.
- **Frame length:** (1 + data bits + parity bits) × `os_tick` + `sb_tick` pulses.
- **`tx_done_tick`:** high in the cycle of the final stop `s_tick`; `ready` rises on the next edge.
- **Back-to-back:** `tx_start` coincident with `tx_done_tick` is ignored because `ready` = 0. The earliest next acceptance is the following cycle, which adds no extra `s_tick` gap beyond one clock.
- **Busy requests:** `tx_start` while `ready` = 0 is dropped; `din` is not re-sampled.

## Structure
- Shared package `uart_pkg`:
  - state encoding;
  - parity mode constants `PAR_NONE` = 0, `PAR_EVEN` = 1, `PAR_ODD` = 2;
  - `DBIT` default.
- One sub-module: `parity_calculator` (ports `data`, `dbit`, `pbit`, `parity`), shared with the receiver so both ends compute parity identically. Instantiate it on `din` at acceptance.

## Test plan
- **8N1, 0xA5** (`os_tick` = 16, `sb_tick` = 16, `s_tick` every 4 clocks): `tx` shows low for 16 ticks, then bits 1,0,1,0,0,1,0,1 at 16 ticks each, then high for 16 ticks. `tx_done_tick` pulses once, and the frame is 160 ticks long.
- **7E1 and 7O1, 0x41:** data bits 1,0,0,0,0,0,1; parity bit is 0 for even and 1 for odd. 0xC1 with `dbit` = 7 produces an identical frame (bit 7 ignored).
- **Stop length** (`sb_tick` = 24 and 32): stop high lasts exactly 24 and 32 ticks. **Zero settings:** `os_tick` = 0 gives 256-tick bits.
- **Busy and back-to-back:** pulse `tx_start` with 0x3C mid-frame; the current frame completes unchanged and no second frame is sent. A `tx_start` held high sends the next frame one clock after `ready` rises.
- **Reset mid-frame:** assert `reset` during data bit 3; `tx` = 1 and `ready` = 1 immediately, with no `tx_done_tick`. A new frame afterwards is correct.
- **Loopback into `uart_rx`:** 200 random words across 8N1, 7E1, 8O2 and `os_tick` values 16 and 32. Every received `dout` matches, `e_parity` = 0 and `e_frame` = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the serial front end (transmitter and receiver):
//   - DBIT_DEFAULT : default width of the data storage
//   - PAR_*        : parity mode encodings carried on the 2-bit pbit input
//   - tx_state_e   : transmitter FSM state encoding
//   - helpers      : frame data width and parity-mode selection
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DBIT_DEFAULT = 8;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Only a runtime setting of 7 selects short frames; every other code means 8.
    function automatic int frame_data_bits(input logic [3:0] dbit);
        int width;
        if (dbit == 4'd7) begin
            width = 32'sd7;
        end else begin
            width = 32'sd8;
        end
        return width;
    endfunction

    // Turn the XOR of the data bits into the line parity bit for the mode.
    // Mode 3 is treated as "none", so it never produces a parity bit.
    function automatic logic apply_parity_mode(input logic xor_bit, input logic [1:0] pbit);
        logic par;
        case (pbit)
            PAR_EVEN: par = xor_bit;
            PAR_ODD:  par = ~xor_bit;
            default:  par = 1'b0;
        endcase
        return par;
    endfunction

    // True when a parity bit is inserted between the data and the stop interval.
    function automatic logic parity_enabled(input logic [1:0] pbit);
        logic en;
        case (pbit)
            PAR_EVEN: en = 1'b1;
            PAR_ODD:  en = 1'b1;
            default:  en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/parity_calculator.sv
// -----------------------------------------------------------------------------
// parity_calculator
// Combinational parity of a data word for the programmed frame format. Used by
// both the transmitter and the receiver so the two ends agree bit for bit.
// Ports:
//   data   [DBIT-1:0] in  : word whose low 7 or 8 bits form the frame payload
//   dbit   [3:0]      in  : data bits per frame (7 = short frame, else 8)
//   pbit   [1:0]      in  : parity mode (PAR_NONE / PAR_EVEN / PAR_ODD / none)
//   parity            out : parity bit to send/expect (0 when parity is off)
// -----------------------------------------------------------------------------
module parity_calculator
    import uart_pkg::*;
#(
    parameter int DBIT = DBIT_DEFAULT
) (
    input  logic [DBIT-1:0] data,
    input  logic [3:0]      dbit,
    input  logic [1:0]      pbit,
    output logic            parity
);

    logic xor_s;

    // Fold only the bits that actually go on the line; anything above the
    // frame width (bit 7 of a 7-bit frame, storage above bit 7) is ignored.
    always_comb begin
        xor_s = 1'b0;
        for (int i = 0; i < DBIT; i++) begin
            if (i < frame_data_bits(dbit)) begin
                xor_s = xor_s ^ data[i];
            end else begin
                xor_s = xor_s;
            end
        end
        parity = apply_parity_mode(xor_s, pbit);
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Runtime-configurable UART transmitter. Sends start bit, 7 or 8 data bits LSB
// first, optional even/odd parity bit and a programmable stop interval. All
// timing advances only on the shared oversample enable s_tick.
// Ports:
//   clk, reset         in  : system clock, asynchronous active-high reset
//   dbit    [3:0]      in  : data bits per frame (7 sends din[6:0], else din[7:0])
//   pbit    [1:0]      in  : parity mode (0 none, 1 even, 2 odd, 3 none)
//   sb_tick [7:0]      in  : stop interval length in s_tick pulses (0 = 256)
//   os_tick [7:0]      in  : s_tick pulses per bit (0 = 256)
//   s_tick             in  : one-cycle oversample enable
//   tx_start           in  : send request, honoured only while ready
//   din     [DBIT-1:0] in  : word to transmit
//   tx                 out : registered serial line, idles high
//   ready              out : high while idle
//   tx_done_tick       out : one-cycle pulse on the final stop s_tick
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT = DBIT_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      dbit,
    input  logic [1:0]      pbit,
    input  logic [7:0]      sb_tick,
    input  logic [7:0]      os_tick,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            ready,
    output logic            tx_done_tick
);

    tx_state_e        state_q, state_d;
    logic [7:0]       s_q, s_d;
    logic [2:0]       n_q, n_d;
    logic [DBIT-1:0]  b_q, b_d;
    logic             p_q, p_d;
    logic             tx_q, tx_d;

    logic             din_par_s;
    logic             done_s;
    logic [7:0]       os_last_s;
    logic [7:0]       sb_last_s;
    logic [2:0]       n_last_s;

    // Parity is computed on din directly so it is ready in the accept cycle.
    parity_calculator #(
        .DBIT (DBIT)
    ) u_parity_calculator (
        .data   (din),
        .dbit   (dbit),
        .pbit   (pbit),
        .parity (din_par_s)
    );

    // Terminal counts; 8-bit wrap makes a setting of 0 mean 256 ticks.
    always_comb begin
        os_last_s = os_tick - 8'd1;
        sb_last_s = sb_tick - 8'd1;
        if (dbit == 4'd7) begin
            n_last_s = 3'd6;
        end else begin
            n_last_s = 3'd7;
        end
    end

    // Next-state, counters, shift register and line level.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        p_d     = p_q;
        done_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    b_d     = din;
                    s_d     = 8'd0;
                    n_d     = 3'd0;
                    p_d     = din_par_s;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                if (s_tick) begin
                    if (s_q == os_last_s) begin
                        s_d     = 8'd0;
                        state_d = ST_DATA;
                    end else begin
                        s_d = s_q + 8'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end

            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == os_last_s) begin
                        s_d = 8'd0;
                        b_d = b_q >> 1;
                        if (n_q == n_last_s) begin
                            n_d = 3'd0;
                            if (parity_enabled(pbit)) begin
                                state_d = ST_PARITY;
                            end else begin
                                state_d = ST_STOP;
                            end
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 8'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end

            ST_PARITY: begin
                if (s_tick) begin
                    if (s_q == os_last_s) begin
                        s_d     = 8'd0;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 8'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end

            ST_STOP: begin
                if (s_tick) begin
                    if (s_q == sb_last_s) begin
                        s_d     = 8'd0;
                        done_s  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        s_d = s_q + 8'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end

            default: begin
                s_d     = 8'd0;
                n_d     = 3'd0;
                state_d = ST_IDLE;
            end
        endcase

        // The line level follows the state being entered, so every bit edge
        // lands on the clock edge that samples the terminal s_tick.
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = b_d[0];
            ST_PARITY: tx_d = p_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset forces the line idle immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= 8'd0;
            n_q     <= 3'd0;
            b_q     <= '0;
            p_q     <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            p_q     <= p_d;
            tx_q    <= tx_d;
        end
    end

    assign tx           = tx_q;
    assign ready        = (state_q == ST_IDLE);
    assign tx_done_tick = done_s;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Directed bench for uart_tx: each frame is captured one sample per s_tick,
// cut into bit cells of os_tick samples and decoded like a receiver would.
// Decoded data, parity and frame lengths are compared with hand-derived values.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    logic       clk;
    logic       reset;
    logic [3:0] dbit;
    logic [1:0] pbit;
    logic [7:0] sb_tick;
    logic [7:0] os_tick;
    logic       s_tick;
    logic       tx_start;
    logic [7:0] din;
    logic       tx;
    logic       ready;
    logic       tx_done_tick;

    int num_checks = 0;
    int num_errors = 0;
    int tick_period = 4;
    int tick_cnt = 0;

    logic cap [0:4095];
    int   cap_len;

    uart_tx #(.DBIT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .dbit         (dbit),
        .pbit         (pbit),
        .sb_tick      (sb_tick),
        .os_tick      (os_tick),
        .s_tick       (s_tick),
        .tx_start     (tx_start),
        .din          (din),
        .tx           (tx),
        .ready        (ready),
        .tx_done_tick (tx_done_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oversample enable: one-cycle pulse every tick_period clocks.
    initial begin
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick_cnt = tick_cnt + 1;
            if (tick_cnt >= tick_period) begin
                tick_cnt = 0;
                s_tick = 1'b1;
            end else begin
                s_tick = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input logic [3:0] d, input logic [1:0] p, input logic [7:0] os,
                           input logic [7:0] sb, input int period);
        dbit = d;
        pbit = p;
        os_tick = os;
        sb_tick = sb;
        tick_period = period;
    endtask

    // Wait for ready, present the word for one edge and confirm acceptance.
    task automatic send_word(input logic [7:0] v, input logic hold);
        int cyc;
        cyc = 0;
        while (ready !== 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("ready_before_send", ready, 1);
        @(posedge clk);
        #1;
        din = v;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            tx_start = 1'b0;
        end
        check_eq("accept_tx", tx, 0);
        check_eq("accept_ready", ready, 0);
    endtask

    // Record tx once per s_tick until the done pulse (bounded).
    task automatic capture_frame();
        int cyc;
        logic done_seen;
        cap_len = 0;
        cyc = 0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (s_tick && cap_len < 4096) begin
                cap[cap_len] = tx;
                cap_len++;
            end
            if (tx_done_tick) begin
                done_seen = 1'b1;
            end
        end
        check_eq("done_seen", done_seen, 1);
    endtask

    // Decode the captured samples into bit cells and compare.
    task automatic check_frame(input string tag, input int w, input int np,
                               input logic [7:0] exp_data, input logic exp_par);
        int os_e, sb_e, nb, bad, idx;
        logic [7:0] d;
        logic pv, sv, v;
        os_e = (os_tick == 8'd0) ? 256 : int'(os_tick);
        sb_e = (sb_tick == 8'd0) ? 256 : int'(sb_tick);
        nb = 1 + w + np;
        bad = 0;
        d = 8'd0;
        pv = 1'b0;
        sv = 1'b1;
        for (int i = 0; i < nb; i++) begin
            idx = i * os_e;
            v = (idx < cap_len) ? cap[idx] : 1'bx;
            for (int j = 0; j < os_e; j++) begin
                if (idx + j >= cap_len || cap[idx + j] !== v) bad++;
            end
            if (i == 0) sv = v;
            else if (i <= w) d[i - 1] = v;
            else pv = v;
        end
        for (int t = nb * os_e; t < cap_len; t++) begin
            if (cap[t] !== 1'b1) bad++;
        end
        check_eq({tag, "_len"}, cap_len, nb * os_e + sb_e);
        check_eq({tag, "_start"}, sv, 0);
        check_eq({tag, "_data"}, d, exp_data);
        if (np != 0) begin
            check_eq({tag, "_par"}, pv, exp_par);
        end
        check_eq({tag, "_cells"}, bad, 0);
    endtask

    // Called at the done cycle: ready must rise on the next edge only.
    task automatic finish_frame(input string tag);
        check_eq({tag, "_rdy_at_done"}, ready, 0);
        @(posedge clk);
        #1;
        check_eq({tag, "_rdy_after"}, ready, 1);
        check_eq({tag, "_done_once"}, tx_done_tick, 0);
        check_eq({tag, "_idle_tx"}, tx, 1);
    endtask

    task automatic do_frame(input string tag, input logic [7:0] v, input int w, input int np,
                            input logic [7:0] exp_data, input logic exp_par);
        send_word(v, 1'b0);
        capture_frame();
        check_frame(tag, w, np, exp_data, exp_par);
        finish_frame(tag);
    endtask

    initial begin
        int n, cyc, busy_cnt, w, np;
        logic [7:0] v, dm;
        logic par;

        reset = 1'b1;
        tx_start = 1'b0;
        din = 8'd0;
        set_cfg(4'd8, 2'd0, 8'd16, 8'd16, 4);

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_ready", ready, 1);
        check_eq("rst_done", tx_done_tick, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("post_rst_tx", tx, 1);
        check_eq("post_rst_ready", ready, 1);

        // 8N1 0xA5: 9 bit cells of 16 plus 16 stop = 160 ticks
        do_frame("a5_8n1", 8'hA5, 8, 0, 8'hA5, 1'b0);
        check_eq("a5_len_hand", cap_len, 160);

        // 7E1 / 7O1 on 0x41 (two ones -> even parity 0), and 0xC1 ignores bit 7
        set_cfg(4'd7, 2'd1, 8'd16, 8'd16, 4);
        do_frame("41_7e1", 8'h41, 7, 1, 8'h41, 1'b0);
        check_eq("41_7e1_len_hand", cap_len, 160);
        set_cfg(4'd7, 2'd2, 8'd16, 8'd16, 4);
        do_frame("41_7o1", 8'h41, 7, 1, 8'h41, 1'b1);
        set_cfg(4'd7, 2'd1, 8'd16, 8'd16, 4);
        do_frame("c1_7e1", 8'hC1, 7, 1, 8'h41, 1'b0);

        // Stop interval lengths
        set_cfg(4'd8, 2'd0, 8'd16, 8'd24, 4);
        do_frame("sb24", 8'h5A, 8, 0, 8'h5A, 1'b0);
        check_eq("sb24_len_hand", cap_len, 168);
        set_cfg(4'd8, 2'd0, 8'd16, 8'd32, 4);
        do_frame("sb32", 8'h5A, 8, 0, 8'h5A, 1'b0);
        check_eq("sb32_len_hand", cap_len, 176);

        // os_tick = 0 means 256-tick bits
        set_cfg(4'd8, 2'd0, 8'd0, 8'd16, 1);
        do_frame("os0", 8'h81, 8, 0, 8'h81, 1'b0);
        check_eq("os0_len_hand", cap_len, 2320);

        // Busy request mid-frame is dropped and din is not re-sampled
        set_cfg(4'd8, 2'd0, 8'd16, 8'd16, 4);
        send_word(8'hA5, 1'b0);
        fork
            capture_frame();
            begin
                repeat (200) @(posedge clk);
                #1;
                din = 8'h3C;
                tx_start = 1'b1;
                @(posedge clk);
                #1;
                tx_start = 1'b0;
            end
        join
        check_frame("busy", 8, 0, 8'hA5, 1'b0);
        finish_frame("busy");
        busy_cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (ready !== 1'b1 || tx !== 1'b1) busy_cnt++;
        end
        check_eq("busy_no_second", busy_cnt, 0);

        // Back-to-back with tx_start held high
        send_word(8'h96, 1'b1);
        din = 8'h69;
        capture_frame();
        check_frame("b2b_1", 8, 0, 8'h96, 1'b0);
        check_eq("b2b_rdy_at_done", ready, 0);
        @(posedge clk);
        #1;
        check_eq("b2b_rdy_rise", ready, 1);
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        check_eq("b2b_accept_ready", ready, 0);
        check_eq("b2b_accept_tx", tx, 0);
        capture_frame();
        check_frame("b2b_2", 8, 0, 8'h69, 1'b0);
        finish_frame("b2b_2");

        // Reset in the middle of data bit 3 (bit 3 of 0xA5 is 0)
        send_word(8'hA5, 1'b0);
        n = 0;
        cyc = 0;
        busy_cnt = 0;
        while (n < 72 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (s_tick) n++;
            if (tx_done_tick) busy_cnt++;
        end
        check_eq("mid_ticks", n, 72);
        check_eq("mid_tx_bit3", tx, 0);
        #1;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_tx", tx, 1);
        check_eq("mid_rst_ready", ready, 1);
        check_eq("mid_rst_done", tx_done_tick, 0);
        check_eq("mid_no_done", busy_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_frame("after_rst", 8'h3C, 8, 0, 8'h3C, 1'b0);

        // Random words across 8N1, 7E1 and 8O2 at 16 and 32 ticks per bit
        for (int k = 0; k < 40; k++) begin
            v = 8'($urandom);
            case (k % 4)
                0: set_cfg(4'd8, 2'd0, 8'd16, 8'd16, 1);
                1: set_cfg(4'd7, 2'd1, 8'd32, 8'd32, 1);
                2: set_cfg(4'd8, 2'd2, 8'd16, 8'd32, 1);
                default: set_cfg(4'd8, 2'd2, 8'd32, 8'd64, 1);
            endcase
            w = (dbit == 4'd7) ? 7 : 8;
            np = (pbit == 2'd0) ? 0 : 1;
            dm = (w == 7) ? (v & 8'h7F) : v;
            par = (pbit == 2'd2) ? ~(^dm) : (^dm);
            do_frame("rand", v, w, np, dm, par);
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
